// File: rtl/receive_fifo.sv
// UART receiver with 2-flop input synchroniser, mid-bit sampling from a down-counting
// bit timer, parity/framing checks and a DEPTH-word output FIFO with overrun reporting.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | line idle; a falling edge starts a frame once re-armed by rxs=1
//   S_START  | waiting for start mid-bit; rxs=1 there means glitch, abort
//   S_DATA   | sampling WIDTH data bits, LSB first
//   S_PARITY | sampling the parity bit (only when PARITY != 0)
//   S_STOP   | sampling STOPS stop bits; last one pushes the word
module receive_fifo #(
  parameter int  BAUDRATE  = 9600,
  parameter real FREQUENCY = 12e6,
  parameter int  WIDTH     = 8,
  parameter int  PARITY    = 0,
  parameter int  STOPS     = 1,
  parameter int  DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxd,
  input  logic                       rdy,
  output logic                       stb,
  output logic [WIDTH-1:0]           dat,
  output logic                       perr,
  output logic                       ferr,
  output logic                       ovr,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int CYCLES = $rtoi(FREQUENCY / BAUDRATE);
  localparam int TW     = $clog2(CYCLES);
  localparam int IW     = $clog2(WIDTH);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int EW     = WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic              rx_meta, rxs;
  state_t            state, state_n;
  logic [TW-1:0]     tmr, tmr_n;
  logic [IW-1:0]     idx, idx_n;
  logic [WIDTH-1:0]  sreg, sreg_n;
  logic              perr_q, perr_n;
  logic              ferr_q, ferr_n;
  logic              stop_idx, stop_n;
  logic              armed, armed_n;
  logic              bit_tick;
  logic              push;
  logic [EW-1:0]     push_word;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wptr, rptr, rptr_n;
  logic [CW-1:0]     count, count_n;
  logic              full, pop, wr;
  logic [EW-1:0]     head_n;
  logic              head_load;

  // rxd is asynchronous; everything downstream only ever looks at rxs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      idx      <= '0;
      sreg     <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      stop_idx <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      idx      <= idx_n;
      sreg     <= sreg_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
      stop_idx <= stop_n;
      armed    <= armed_n;
    end
  end

  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    idx_n     = idx;
    sreg_n    = sreg;
    perr_n    = perr_q;
    ferr_n    = ferr_q;
    stop_n    = stop_idx;
    armed_n   = armed;
    push      = 1'b0;
    bit_tick  = (tmr == '0);
    case (state)
      S_IDLE: begin
        if (rxs) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n = S_START;
          tmr_n   = TW'(CYCLES / 2 - 1);
          armed_n = 1'b0;
        end
      end
      S_START: begin
        if (!bit_tick) begin
          tmr_n = tmr - TW'(1);
        end else if (rxs) begin
          state_n = S_IDLE;
          armed_n = 1'b1;
        end else begin
          state_n = S_DATA;
          tmr_n   = TW'(CYCLES - 1);
          idx_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      S_DATA: begin
        if (!bit_tick) begin
          tmr_n = tmr - TW'(1);
        end else begin
          sreg_n[idx] = rxs;
          tmr_n       = TW'(CYCLES - 1);
          if (idx == IW'(WIDTH - 1)) begin
            stop_n  = 1'b0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (!bit_tick) begin
          tmr_n = tmr - TW'(1);
        end else begin
          perr_n  = ((^sreg) ^ rxs) != (PARITY == 1);
          tmr_n   = TW'(CYCLES - 1);
          stop_n  = 1'b0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (!bit_tick) begin
          tmr_n = tmr - TW'(1);
        end else begin
          ferr_n = ferr_q | ~rxs;
          if (stop_idx == 1'(STOPS - 1)) begin
            push    = 1'b1;
            state_n = S_IDLE;
            // a low line here is a break: wait for it to go high before re-arming
            armed_n = rxs;
          end else begin
            stop_n = 1'b1;
            tmr_n  = TW'(CYCLES - 1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    push_word = {ferr_n, perr_q, sreg};
  end

  assign full = (count == CW'(DEPTH));
  assign stb  = (count != '0);
  assign cnt  = count;
  assign pop  = stb && rdy;
  assign wr   = push && (!full || pop);

  always_comb begin
    rptr_n    = rptr + PW'(pop);
    count_n   = count + CW'(wr) - CW'(pop);
    head_load = (count_n != '0);
    // if the FIFO drains to nothing this cycle, the incoming word becomes head directly
    if ((count - CW'(pop)) == '0) begin
      head_n = push_word;
    end else begin
      head_n = mem[rptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dat   <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      wptr  <= wptr + PW'(wr);
      rptr  <= rptr_n;
      count <= count_n;
      ovr   <= push && full && !pop;
      if (head_load) begin
        ferr <= head_n[EW-1];
        perr <= head_n[EW-2];
        dat  <= head_n[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_receive_fifo.sv
// Bench for receive_fifo: two instances (8N1 and 8E2), 16 clocks per bit; directed
// frames push expected words into per-instance queues that negedge monitors pop and compare.
module tb_receive_fifo;

  localparam int  CYC  = 16;
  localparam real FREQ = 153600.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       rdy_a = 1'b0, rdy_b = 1'b1;
  logic       stb_a, stb_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;
  logic [7:0] dat_a, dat_b;
  logic [2:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;
  int ovr_cyc_a = 0;
  int ovr_base;
  int n;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];

  always #5 clk = ~clk;

  receive_fifo #(.BAUDRATE(9600), .FREQUENCY(FREQ), .WIDTH(8), .PARITY(0), .STOPS(1), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rdy(rdy_a), .stb(stb_a), .dat(dat_a),
    .perr(perr_a), .ferr(ferr_a), .ovr(ovr_a), .cnt(cnt_a));

  receive_fifo #(.BAUDRATE(9600), .FREQUENCY(FREQ), .WIDTH(8), .PARITY(2), .STOPS(2), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rdy(rdy_b), .stb(stb_b), .dat(dat_b),
    .perr(perr_b), .ferr(ferr_b), .ovr(ovr_b), .cnt(cnt_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // word format in the queues: {perr, ferr, dat}
  always @(negedge clk) begin
    if (!rst) begin
      if (ovr_a) ovr_cyc_a++;
      if (stb_a && rdy_a) begin
        if (exp_a.size() == 0) note_fail("a_unexpected_word", {22'd0, perr_a, ferr_a, dat_a});
        else check("a_word", {22'd0, perr_a, ferr_a, dat_a}, {22'd0, exp_a.pop_front()});
      end
      if (stb_b && rdy_b) begin
        if (exp_b.size() == 0) note_fail("b_unexpected_word", {22'd0, perr_b, ferr_b, dat_b});
        else check("b_word", {22'd0, perr_b, ferr_b, dat_b}, {22'd0, exp_b.pop_front()});
      end
    end
  end

  task automatic tk(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rxd(input int line, input logic v);
    if (line == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input int pbit,
                            input logic stopv, input int nstops);
    set_rxd(line, 1'b0);
    tk(CYC);
    for (int i = 0; i < 8; i++) begin
      set_rxd(line, d[i]);
      tk(CYC);
    end
    if (pbit >= 0) begin
      set_rxd(line, pbit[0]);
      tk(CYC);
    end
    for (int i = 0; i < nstops; i++) begin
      set_rxd(line, stopv);
      tk(CYC);
    end
  endtask

  task automatic wait_drain(input int line, input int budget);
    int k;
    k = 0;
    while (((line == 0) ? exp_a.size() : exp_b.size()) != 0 && k < budget) begin
      tk(1);
      k++;
    end
    if (k >= budget) note_fail("drain_timeout", line);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tk(3);
    check("rst_stb", stb_a, 0);
    check("rst_dat", dat_a, 0);
    check("rst_perr", perr_a, 0);
    check("rst_ferr", ferr_a, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_stb_b", stb_b, 0);
    rst = 1'b0;
    tk(4);

    // 1: 8N1 0xA5, held then popped
    rdy_a = 1'b0;
    send_frame(0, 8'hA5, -1, 1'b1, 1);
    n = 0;
    while (!stb_a && n < CYC) begin
      tk(1);
      n++;
    end
    check("t1_stb", stb_a, 1);
    check("t1_cnt", cnt_a, 1);
    check("t1_dat", dat_a, 8'hA5);
    exp_a.push_back({2'b00, 8'hA5});
    rdy_a = 1'b1;
    tk(1);
    check("t1_stb_drop", stb_a, 0);
    check("t1_queue", exp_a.size(), 0);

    // 2: even parity, bad then good parity bit
    exp_b.push_back({2'b10, 8'h07});
    send_frame(1, 8'h07, 0, 1'b1, 2);
    exp_b.push_back({2'b00, 8'h07});
    send_frame(1, 8'h07, 1, 1'b1, 2);
    wait_drain(1, 4 * CYC);
    check("t2_cnt_b", cnt_b, 0);

    // 3: framing error followed by a break
    exp_a.push_back({2'b01, 8'h55});
    send_frame(0, 8'h55, -1, 1'b0, 1);
    tk(3 * CYC);
    wait_drain(0, 4);
    check("t3_break_cnt", cnt_a, 0);
    check("t3_break_stb", stb_a, 0);
    rxd_a = 1'b1;
    tk(CYC);
    exp_a.push_back({2'b00, 8'hC3});
    send_frame(0, 8'hC3, -1, 1'b1, 1);
    wait_drain(0, 4 * CYC);

    // 4: overrun with consumer stalled
    rdy_a = 1'b0;
    ovr_base = ovr_cyc_a;
    for (int i = 1; i <= 4; i++) exp_a.push_back({2'b00, 8'(i)});
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), -1, 1'b1, 1);
    tk(4);
    check("t4_cnt", cnt_a, 4);
    check("t4_ovr_cycles", ovr_cyc_a - ovr_base, 1);
    check("t4_head", dat_a, 8'h01);
    rdy_a = 1'b1;
    wait_drain(0, 4 * CYC);
    tk(2);
    check("t4_cnt_after", cnt_a, 0);

    // 5: short low glitch rejected
    rxd_a = 1'b0;
    tk(CYC / 4);
    rxd_a = 1'b1;
    tk(2 * CYC);
    check("t5_cnt", cnt_a, 0);
    check("t5_stb", stb_a, 0);
    exp_a.push_back({2'b00, 8'h3C});
    send_frame(0, 8'h3C, -1, 1'b1, 1);
    wait_drain(0, 4 * CYC);

    // 6: reset pulse in the middle of data bit 3
    rxd_a = 1'b0;
    tk(CYC);
    tk(3 * CYC);
    tk(CYC / 2);
    rst = 1'b1;
    rxd_a = 1'b1;
    tk(1);
    rst = 1'b0;
    check("t6_stb", stb_a, 0);
    check("t6_cnt", cnt_a, 0);
    tk(2 * CYC);
    check("t6_idle_cnt", cnt_a, 0);
    exp_a.push_back({2'b00, 8'h81});
    send_frame(0, 8'h81, -1, 1'b1, 1);
    wait_drain(0, 4 * CYC);
    tk(4);
    check("end_cnt_a", cnt_a, 0);
    check("end_ovr_total", ovr_cyc_a - ovr_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
